// File: rtl/vec_wb_collector_pkg.sv
// Shared definitions for the vector writeback collector: op-type and element-width
// codes, FSM state encoding, and the active-lane helper.
package vec_wb_collector_pkg;

    localparam logic [1:0] OP_VV = 2'd0;
    localparam logic [1:0] OP_VX = 2'd1;
    localparam logic [1:0] OP_VI = 2'd2;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    localparam int LANE_DATA_W = 64;
    localparam int LANE_IDX_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } wb_state_e;

    // Lane participates when its number is below 1<<nb.
    function automatic logic lane_active(input int unsigned lane, input logic [1:0] nb);
        return (lane >> nb) == 0;
    endfunction

endpackage

// File: rtl/vec_wb_mask_expand.sv
// Element mask -> byte-enable expansion: byte b belongs to element b>>vsew,
// and inherits that element's v0 bit unless vm disables masking.
module vec_wb_mask_expand #(
    parameter int VLEN = 128
) (
    input  logic              vm,
    input  logic [VLEN-1:0]   v0_mask,
    input  logic [2:0]        vsew,
    output logic [VLEN/8-1:0] be
);
    localparam int EW = $clog2(VLEN);

    logic [EW-1:0] elem;

    always_comb begin
        elem = '0;
        be   = '0;
        for (int b = 0; b < VLEN / 8; b++) begin
            elem  = EW'(b >> vsew);
            be[b] = vm | v0_mask[elem];
        end
    end

endmodule

// File: rtl/vec_wb_collector.sv
// Vector writeback collector: gathers per-lane result chunks into a VLEN-bit buffer,
// then issues one register-file write. Optional masking under VEC_WB_MASK_EN.
module vec_wb_collector
    import vec_wb_collector_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4,
    parameter int NB_LANES   = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [4:0]                     vd_addr,
    input  logic [1:0]                     nb_lanes,
    input  logic [2:0]                     vsew,
    input  logic [NB_LANES-1:0]            lane_valid,
    input  logic [NB_LANES*LANE_DATA_W-1:0] lane_data,
    input  logic [NB_LANES*LANE_IDX_W-1:0]  lane_index,
    input  logic [NB_LANES-1:0]            lane_done,
`ifdef VEC_WB_MASK_EN
    input  logic                           vm,
    input  logic [VLEN-1:0]                v0_mask,
`endif
    output logic                           vrf_wr_en,
    output logic [4:0]                     vrf_wr_addr,
    output logic [VLEN-1:0]                vrf_wr_data,
    output logic [VLEN/8-1:0]              vrf_wr_be,
    input  logic                           vrf_wr_ready,
    output logic                           busy,
    output logic                           wb_done,
    output logic                           wb_err
);
    localparam int CW   = 1 << LANE_WIDTH;
    localparam int BE_W = VLEN / 8;
    localparam logic [VLEN-1:0] CHUNK_MASK = VLEN'({CW{1'b1}});

    wb_state_e           state;
    logic [VLEN-1:0]     buffer;
    logic [NB_LANES-1:0] done_mask;
    logic [1:0]          nb_q;

    logic [VLEN-1:0]     buf_nxt;
    logic                err_hit;
    logic [NB_LANES-1:0] active;
    logic [NB_LANES-1:0] done_nxt;
    logic                all_done;

    for (genvar l = 0; l < NB_LANES; l++) begin : g_active
        assign active[l] = lane_active(l, nb_q);
    end

    // Lanes applied in ascending order so the higher lane wins on overlap.
    always_comb begin
        buf_nxt = buffer;
        err_hit = 1'b0;
        for (int l = 0; l < NB_LANES; l++) begin
            if (active[l] && lane_valid[l]) begin
                if ({1'b0, lane_index[l*LANE_IDX_W +: LANE_IDX_W]} + 11'(CW) > 11'(VLEN))
                    err_hit = 1'b1;
                else
                    buf_nxt = (buf_nxt & ~(CHUNK_MASK << lane_index[l*LANE_IDX_W +: LANE_IDX_W]))
                            | (VLEN'(lane_data[l*LANE_DATA_W +: CW])
                               << lane_index[l*LANE_IDX_W +: LANE_IDX_W]);
            end
        end
    end

    assign done_nxt = done_mask | (lane_done & active);
    assign all_done = &(done_nxt | ~active);

`ifdef VEC_WB_MASK_EN
    logic [BE_W-1:0] be_start;
    logic [BE_W-1:0] be_q;

    vec_wb_mask_expand #(.VLEN(VLEN)) u_mask_expand (
        .vm      (vm),
        .v0_mask (v0_mask),
        .vsew    (vsew),
        .be      (be_start)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            be_q <= '1;
        else if (state == ST_IDLE && start)
            be_q <= be_start;
    end

    assign vrf_wr_be = be_q;
`else
    assign vrf_wr_be = {BE_W{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            buffer      <= '0;
            done_mask   <= '0;
            nb_q        <= '0;
            vrf_wr_en   <= 1'b0;
            vrf_wr_addr <= '0;
            wb_done     <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vrf_wr_addr <= vd_addr;
                        nb_q        <= nb_lanes;
                        buffer      <= '0;
                        done_mask   <= '0;
                        wb_err      <= 1'b0;
                        state       <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    buffer    <= buf_nxt;
                    done_mask <= done_nxt;
                    if (err_hit)
                        wb_err <= 1'b1;
                    if (all_done) begin
                        vrf_wr_en <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (vrf_wr_ready) begin
                        vrf_wr_en <= 1'b0;
                        wb_done   <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign vrf_wr_data = buffer;
    assign busy        = (state != ST_IDLE);

    // Only the low CW bits of each lane result are written back.
    logic [NB_LANES-1:0] unused_hi;
    for (genvar l = 0; l < NB_LANES; l++) begin : g_unused
        if (CW < LANE_DATA_W) begin : g_hi
            assign unused_hi[l] = ^lane_data[l*LANE_DATA_W+CW +: LANE_DATA_W-CW];
        end else begin : g_none
            assign unused_hi[l] = 1'b0;
        end
    end
    logic unused;
    assign unused = ^{unused_hi, vsew};

endmodule

// File: tb/tb_vec_wb_collector.sv
// Randomized self-checking bench for vec_wb_collector; masked checks enabled
// when compiled with VEC_WB_MASK_EN.
module tb_vec_wb_collector;
    localparam int VLEN = 128;
    localparam int CW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn, start, vrf_wr_ready;
    logic [4:0]   vd_addr;
    logic [1:0]   nb_lanes;
    logic [2:0]   vsew;
    logic [3:0]   lane_valid, lane_done;
    logic [255:0] lane_data;
    logic [39:0]  lane_index;
    logic         vrf_wr_en, busy, wb_done, wb_err;
    logic [4:0]   vrf_wr_addr;
    logic [127:0] vrf_wr_data;
    logic [15:0]  vrf_wr_be;
`ifdef VEC_WB_MASK_EN
    logic         vm;
    logic [127:0] v0_mask;
`endif

    vec_wb_collector dut (
        .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr),
        .nb_lanes(nb_lanes), .vsew(vsew), .lane_valid(lane_valid),
        .lane_data(lane_data), .lane_index(lane_index), .lane_done(lane_done),
`ifdef VEC_WB_MASK_EN
        .vm(vm), .v0_mask(v0_mask),
`endif
        .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data),
        .vrf_wr_be(vrf_wr_be), .vrf_wr_ready(vrf_wr_ready), .busy(busy),
        .wb_done(wb_done), .wb_err(wb_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what the register write should carry.
    logic [127:0] ref_buf;
    bit           ref_err;
    int           act;
    logic [4:0]   ref_addr;
    bit           ref_vm;
    logic [127:0] ref_mask;
    int           ref_sew;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        lane_valid = '0; lane_done = '0; lane_data = '0; lane_index = '0;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [15:0] exp_be();
        logic [15:0] r;
        r = '1;
`ifdef VEC_WB_MASK_EN
        if (!ref_vm)
            for (int b = 0; b < 16; b++) r[b] = ref_mask[b / (1 << ref_sew)];
`endif
        return r;
    endfunction

    task automatic do_start(input logic [4:0] a, input logic [1:0] nb, input logic [2:0] sew,
                            input bit m_vm, input logic [127:0] m_mask);
        vd_addr = a; nb_lanes = nb; vsew = sew;
`ifdef VEC_WB_MASK_EN
        vm = m_vm; v0_mask = m_mask;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        vd_addr = 5'($urandom); nb_lanes = 2'($urandom); vsew = 3'($urandom);
`ifdef VEC_WB_MASK_EN
        vm = 1'($urandom); v0_mask = {r64(), r64()};
`endif
        ref_buf = '0; ref_err = 0; ref_addr = a;
        act = (nb >= 2) ? 4 : (1 << nb);
        ref_vm = m_vm; ref_mask = m_mask; ref_sew = int'(sew);
    endtask

    // One collect cycle; the model writes bit by bit in lane order.
    task automatic apply(input logic [3:0] v, input logic [255:0] d,
                         input logic [39:0] ix, input logic [3:0] dn);
        lane_valid = v; lane_data = d; lane_index = ix; lane_done = dn;
        for (int l = 0; l < 4; l++) begin
            if (v[l] && l < act) begin
                int i;
                i = int'(ix[l*10 +: 10]);
                if (i + CW > VLEN) ref_err = 1;
                else for (int b = 0; b < CW; b++) ref_buf[i + b] = d[l*64 + b];
            end
        end
        tick();
        clear_lanes();
    endtask

    task automatic release_write(input int hold, output int dcnt, output bit stable,
                                 output bit done_after);
        logic [4:0]   a0;
        logic [127:0] d0;
        logic [15:0]  b0;
        a0 = vrf_wr_addr; d0 = vrf_wr_data; b0 = vrf_wr_be;
        stable = 1; dcnt = 0;
        repeat (hold) begin
            vrf_wr_ready = 1'b0;
            tick();
            if (vrf_wr_en !== 1'b1 || vrf_wr_addr !== a0 || vrf_wr_data !== d0 || vrf_wr_be !== b0)
                stable = 0;
            if (wb_done) dcnt++;
        end
        vrf_wr_ready = 1'b1;
        tick();
        vrf_wr_ready = 1'b0;
        done_after = wb_done;
        if (wb_done) dcnt++;
        repeat (3) begin
            tick();
            if (wb_done) dcnt++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; vrf_wr_ready = 1'b0;
        vd_addr = '0; nb_lanes = '0; vsew = '0;
`ifdef VEC_WB_MASK_EN
        vm = 1'b1; v0_mask = '0;
`endif
        clear_lanes();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        vectors++; if (vrf_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%0b exp=0", vrf_wr_en); end
        vectors++; if (wb_done !== 1'b0 || wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got=%0b%0b exp=00", wb_done, wb_err); end
        vectors++; if (vrf_wr_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", vrf_wr_addr); end
        vectors++; if (vrf_wr_be !== 16'hFFFF) begin miscompares++; $display("FAIL reset_be got=%h exp=ffff", vrf_wr_be); end
        vectors++; if (vrf_wr_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", vrf_wr_data); end
    endtask

    task automatic test_basic();
        int dc; bit st, da;
        do_start(5'd3, 2'd2, 3'd0, 1'b1, '0);
        apply(4'hF, {64'hDD, 64'hCC, 64'hBB, 64'hAA}, {10'd48, 10'd32, 10'd16, 10'd0}, 4'h0);
        vectors++; if (vrf_wr_en !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_collect en=%0b busy=%0b exp en=0 busy=1", vrf_wr_en, busy); end
        apply(4'h0, '0, '0, 4'hF);
        vectors++; if (vrf_wr_en !== 1'b1 || vrf_wr_addr !== 5'd3) begin miscompares++; $display("FAIL basic_write en=%0b addr=%0d exp en=1 addr=3", vrf_wr_en, vrf_wr_addr); end
        vectors++; if (vrf_wr_data[63:0] !== 64'h00DD00CC00BB00AA) begin miscompares++; $display("FAIL basic_data got=%h exp=00dd00cc00bb00aa", vrf_wr_data[63:0]); end
        vectors++; if (vrf_wr_data !== ref_buf || vrf_wr_be !== exp_be()) begin miscompares++; $display("FAIL basic_full data=%h be=%h exp data=%h be=%h", vrf_wr_data, vrf_wr_be, ref_buf, exp_be()); end
        release_write(0, dc, st, da);
        vectors++; if (da !== 1'b1 || dc != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_wb_done after=%0b count=%0d busy=%0b exp 1,1,0", da, dc, busy); end
    endtask

    task automatic test_backpressure();
        int dc; bit st, da;
        logic [255:0] d; logic [39:0] ix;
        d = {r64(), r64(), r64(), r64()};
        for (int l = 0; l < 4; l++) ix[l*10 +: 10] = 10'($urandom_range(0, 112));
        do_start(5'($urandom), 2'd2, 3'($urandom_range(0, 3)), 1'($urandom), {r64(), r64()});
        apply(4'hF, d, ix, 4'hF);
        vectors++; if (vrf_wr_en !== 1'b1 || vrf_wr_data !== ref_buf || vrf_wr_addr !== ref_addr) begin miscompares++; $display("FAIL bp_write en=%0b data=%h addr=%0d exp data=%h addr=%0d", vrf_wr_en, vrf_wr_data, vrf_wr_addr, ref_buf, ref_addr); end
        vectors++; if (vrf_wr_be !== exp_be()) begin miscompares++; $display("FAIL bp_be got=%h exp=%h", vrf_wr_be, exp_be()); end
        release_write(5, dc, st, da);
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL bp_stable got=%0b exp=1", st); end
        vectors++; if (dc != 1 || da !== 1'b1) begin miscompares++; $display("FAIL bp_wb_done count=%0d after=%0b exp 1,1", dc, da); end
    endtask

    task automatic test_stagger();
        int dc; bit st, da, early;
        logic [3:0] sched [1:6];
        sched[1] = 4'b0001; sched[2] = 4'b0000; sched[3] = 4'b0100;
        sched[4] = 4'b0010; sched[5] = 4'b0000; sched[6] = 4'b1000;
        early = 0;
        do_start(5'd9, 2'd2, 3'd0, 1'b1, '0);
        for (int c = 1; c <= 6; c++) begin
            logic [39:0] ix;
            for (int l = 0; l < 4; l++) ix[l*10 +: 10] = 10'($urandom_range(0, 112));
            apply(4'($urandom), {r64(), r64(), r64(), r64()}, ix, sched[c]);
            if (c < 6 && vrf_wr_en !== 1'b0) early = 1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL stagger_early got=1 exp=0"); end
        vectors++; if (vrf_wr_en !== 1'b1 || vrf_wr_data !== ref_buf) begin miscompares++; $display("FAIL stagger_c7 en=%0b data=%h exp en=1 data=%h", vrf_wr_en, vrf_wr_data, ref_buf); end
        release_write(1, dc, st, da);
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL stagger_done got=%0d exp=1", dc); end
    endtask

    task automatic test_inactive_lanes();
        int dc; bit st, da;
        logic [63:0] d0, d1;
        d0 = r64(); d1 = r64();
        do_start(5'd5, 2'd1, 3'd0, 1'b1, '0);
        apply(4'b1001, {64'hFFFF, 64'h0, 64'h0, d0}, {10'd0, 10'd0, 10'd0, 10'd32}, 4'b1000);
        apply(4'b0110, {64'h0, 64'hFFFF, d1, 64'h0}, {10'd0, 10'd0, 10'd64, 10'd0}, 4'b0100);
        apply(4'b1000, {64'hFFFF, 192'h0}, 40'h0, 4'b1101);
        vectors++; if (vrf_wr_en !== 1'b0) begin miscompares++; $display("FAIL inact_early got=1 exp=0"); end
        apply(4'b1000, {64'hFFFF, 192'h0}, 40'h0, 4'b1010);
        vectors++; if (vrf_wr_en !== 1'b1) begin miscompares++; $display("FAIL inact_write got=0 exp=1"); end
        vectors++; if (vrf_wr_data[15:0] !== 16'h0 || vrf_wr_data !== ref_buf) begin miscompares++; $display("FAIL inact_data got=%h exp=%h", vrf_wr_data, ref_buf); end
        vectors++; if (vrf_wr_data[47:32] !== d0[15:0] || vrf_wr_data[79:64] !== d1[15:0]) begin miscompares++; $display("FAIL inact_chunks got=%h/%h exp=%h/%h", vrf_wr_data[47:32], vrf_wr_data[79:64], d0[15:0], d1[15:0]); end
        release_write(0, dc, st, da);
    endtask

    task automatic test_out_of_range();
        int dc; bit st, da;
        logic [63:0] d0, d1;
        d0 = r64(); d1 = r64();
        do_start(5'd7, 2'd2, 3'd0, 1'b1, '0);
        apply(4'b0011, {128'h0, d1, d0}, {10'd0, 10'd0, 10'd112, 10'd120}, 4'hF);
        vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("FAIL oob_err got=%0b exp=1", wb_err); end
        vectors++; if (vrf_wr_en !== 1'b1 || vrf_wr_data !== ref_buf) begin miscompares++; $display("FAIL oob_data en=%0b data=%h exp en=1 data=%h", vrf_wr_en, vrf_wr_data, ref_buf); end
        vectors++; if (vrf_wr_data[127:112] !== d1[15:0] || vrf_wr_data[111:0] !== '0) begin miscompares++; $display("FAIL oob_boundary got=%h exp=%h", vrf_wr_data, {d1[15:0], 112'h0}); end
        release_write(0, dc, st, da);
        vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("FAIL oob_sticky got=%0b exp=1", wb_err); end
        do_start(5'd8, 2'd0, 3'd0, 1'b1, '0);
        vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL oob_clear got=%0b exp=0", wb_err); end
        apply(4'h0, '0, '0, 4'h1);
        release_write(0, dc, st, da);
    endtask

    task automatic test_overlap();
        int dc; bit st, da;
        logic [63:0] d [4];
        for (int l = 0; l < 4; l++) d[l] = r64();
        do_start(5'd11, 2'd2, 3'd0, 1'b1, '0);
        apply(4'hF, {d[3], d[2], d[1], d[0]}, {10'd40, 10'd40, 10'd40, 10'd40}, 4'h0);
        apply(4'b0110, {64'h0, d[2], d[1], 64'h0}, {10'd0, 10'd88, 10'd80, 10'd0}, 4'hF);
        vectors++; if (vrf_wr_data[55:40] !== d[3][15:0]) begin miscompares++; $display("FAIL ovl_same got=%h exp=%h", vrf_wr_data[55:40], d[3][15:0]); end
        vectors++; if (vrf_wr_data[103:80] !== {d[2][15:0], d[1][7:0]}) begin miscompares++; $display("FAIL ovl_partial got=%h exp=%h", vrf_wr_data[103:80], {d[2][15:0], d[1][7:0]}); end
        release_write(0, dc, st, da);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int n, dc; bit st, da, early;
            int dcyc [4];
            logic [1:0] nb;
            nb = 2'($urandom);
            n = $urandom_range(3, 6);
            do_start(5'($urandom), nb, 3'($urandom_range(0, 3)), 1'($urandom), {r64(), r64()});
            for (int l = 0; l < 4; l++) dcyc[l] = $urandom_range(0, n - 1);
            dcyc[$urandom_range(0, act - 1)] = n - 1;
            early = 0;
            for (int c = 0; c < n; c++) begin
                logic [39:0] ix; logic [3:0] dn;
                for (int l = 0; l < 4; l++) begin
                    ix[l*10 +: 10] = ($urandom_range(0, 99) < 85) ? 10'($urandom_range(0, 112))
                                                                  : 10'($urandom_range(113, 1023));
                    dn[l] = (l < act) ? (c == dcyc[l]) : 1'($urandom);
                end
                apply(4'($urandom), {r64(), r64(), r64(), r64()}, ix, dn);
                if (c < n - 1 && vrf_wr_en !== 1'b0) early = 1;
            end
            vectors++; if (early !== 1'b0 || vrf_wr_en !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_timing early=%0b en=%0b exp 0,1", t, early, vrf_wr_en); end
            vectors++; if (vrf_wr_data !== ref_buf || vrf_wr_addr !== ref_addr) begin miscompares++; $display("FAIL rnd%0d_data data=%h addr=%0d exp data=%h addr=%0d", t, vrf_wr_data, vrf_wr_addr, ref_buf, ref_addr); end
            vectors++; if (vrf_wr_be !== exp_be() || wb_err !== ref_err) begin miscompares++; $display("FAIL rnd%0d_be_err be=%h err=%0b exp be=%h err=%0b", t, vrf_wr_be, wb_err, exp_be(), ref_err); end
            release_write($urandom_range(0, 3), dc, st, da);
            vectors++; if (st !== 1'b1 || dc != 1 || da !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_release stable=%0b count=%0d after=%0b exp 1,1,1", t, st, dc, da); end
        end
    endtask

    task automatic test_reset_mid_and_mask();
        int dc, seen; bit st, da;
        do_start(5'd12, 2'd2, 3'd1, 1'b1, '0);
        apply(4'hF, {r64(), r64(), r64(), r64()}, {10'd0, 10'd16, 10'd32, 10'd48}, 4'hF);
        vectors++; if (vrf_wr_en !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre got=0 exp=1"); end
        vrf_wr_ready = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0 || vrf_wr_en !== 1'b0 || vrf_wr_addr !== 5'd0) begin miscompares++; $display("FAIL rst_mid_idle busy=%0b en=%0b addr=%0d exp 0,0,0", busy, vrf_wr_en, vrf_wr_addr); end
        resetn = 1'b1;
        vrf_wr_ready = 1'b1;
        seen = 0;
        repeat (4) begin tick(); if (wb_done) seen++; end
        vrf_wr_ready = 1'b0;
        vectors++; if (seen != 0 || vrf_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_done count=%0d en=%0b exp 0,0", seen, vrf_wr_en); end
        do_start(5'd4, 2'd2, 3'd1, 1'b0, 128'h5);
        apply(4'h0, '0, '0, 4'hF);
`ifdef VEC_WB_MASK_EN
        vectors++; if (vrf_wr_be !== 16'h0033) begin miscompares++; $display("FAIL mask_be got=%h exp=0033", vrf_wr_be); end
`else
        vectors++; if (vrf_wr_be !== 16'hFFFF) begin miscompares++; $display("FAIL nomask_be got=%h exp=ffff", vrf_wr_be); end
`endif
        vectors++; if (vrf_wr_en !== 1'b1 || vrf_wr_addr !== 5'd4) begin miscompares++; $display("FAIL mask_write en=%0b addr=%0d exp 1,4", vrf_wr_en, vrf_wr_addr); end
        release_write(0, dc, st, da);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stagger();
        test_inactive_lanes();
        test_out_of_range();
        test_overlap();
        test_random();
        test_reset_mid_and_mask();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
